// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         WORD_BYTES        = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four accepted bytes into a 32-bit word; word_ready strobes with the 4th byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_vld,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  idx;
  logic [31:0] sr;
  logic [31:0] sr_nx;

  assign sr_nx      = BIG_ENDIAN ? {sr[23:0], byte_in} : {byte_in, sr[31:8]};
  assign word_ready = byte_vld && (idx == 2'(WORD_BYTES - 1));

  // word only updates on completion so it stays stable through the RAM write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx  <= '0;
      sr   <= '0;
      word <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (byte_vld) begin
      sr  <= sr_nx;
      idx <= idx + 2'd1;
      if (word_ready)
        word <= sr_nx;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM loader: framed byte stream -> 32-bit word writes.
// Optional trailing XOR checksum enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W     = 6,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter bit         BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

  state_t            state, state_nx;
  logic              acc;
  logic              is_sync;
  logic [8:0]        n_words;
  logic [8:0]        rem;
  logic [ADDR_W-1:0] wa_q;
  logic              word_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign acc     = in_valid && in_ready;
  assign is_sync = (in_data == SYNC_BYTE);
  assign n_words = (in_data == 8'd0) ? DEPTH : {1'b0, in_data};

  imem_loader_byte_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (state == COUNT),
    .byte_in    (in_data),
    .byte_vld   (acc && (state == DATA)),
    .word       (wd),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (acc && is_sync) state_nx = COUNT;
      COUNT: if (acc) state_nx = ({1'b0, in_data} > DEPTH) ? ERR : DATA;
      DATA:  if (word_ready) state_nx = WRITE;
      WRITE: begin
        if (rem > 9'd1)
          state_nx = DATA;
        else
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nx = CHK;
`else
          state_nx = DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:   if (acc) state_nx = (in_data == csum) ? DONE : ERR;
`endif
      DONE:  if (acc && is_sync) state_nx = COUNT;
      ERR:   if (acc && is_sync) state_nx = COUNT;
      default: state_nx = IDLE;
    endcase
  end

  // address wrap falls out of ADDR_W-bit arithmetic; only a full-depth frame reaches it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem  <= '0;
      wa_q <= '0;
    end else if (state == COUNT && acc) begin
      rem  <= n_words;
      wa_q <= '0;
    end else if (state == WRITE) begin
      rem  <= rem - 9'd1;
      wa_q <= wa_q + ADDR_W'(1);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      csum <= '0;
    else if (state == COUNT && acc)
      csum <= '0;
    else if (state == DATA && acc)
      csum <= csum ^ in_data;
  end
`endif

  assign we       = (state == WRITE);
  assign wa       = wa_q;
  assign in_ready = (state != WRITE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  assign cpu_hold = (state != DONE);

endmodule
